// File: rtl/coil_step_tracker_if.sv
// Bundle between a stepper coil driver tap and the coil_step_tracker.
// The master side owns the coil pattern and the zero/clear requests; the tracker reports position and status.
interface coil_step_tracker_if #(
   parameter int POS_W = 24
);
   logic [3:0]              coil;
   logic                    zero;
   logic                    clr_fault;
   logic signed [POS_W-1:0] position;
   logic                    step_pulse;
   logic                    step_dir;
   logic                    energized;
   logic                    at_min;
   logic                    at_max;
   logic                    fault;

   modport master (
      output coil, zero, clr_fault,
      input  position, step_pulse, step_dir, energized, at_min, at_max, fault
   );

   modport slave (
      input  coil, zero, clr_fault,
      output position, step_pulse, step_dir, energized, at_min, at_max, fault
   );
endinterface

// File: rtl/coil_step_tracker.sv
// Per-axis step tracker: synchronises and debounces the driver coil pattern,
// decodes phase transitions into signed steps, and keeps a saturating position.
module coil_step_tracker #(
   parameter int                      POS_W         = 24,
   parameter int                      STABLE_CYCLES = 4,
   parameter logic signed [POS_W-1:0] POS_MIN       = POS_W'(-8000),
   parameter logic signed [POS_W-1:0] POS_MAX       = POS_W'(8000)
) (
   input logic           PCLK,
   input logic           PRESERN,
   coil_step_tracker_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PH1  = 3'd1,
      S_PH2  = 3'd2,
      S_PH3  = 3'd3,
      S_PH4  = 3'd4,
      S_BAD  = 3'd5
   } state_t;

   localparam logic [3:0]              SC         = 4'(STABLE_CYCLES);
   localparam logic signed [POS_W-1:0] POS_ZERO   = '0;
   localparam logic signed [POS_W-1:0] POS_ONE    = POS_W'(1);
   localparam logic signed [POS_W-1:0] POS_TOP    = {1'b0, {(POS_W-1){1'b1}}};
   localparam logic signed [POS_W-1:0] POS_BOT    = {1'b1, {(POS_W-1){1'b0}}};
   localparam logic                    RST_AT_MIN = (POS_ZERO <= POS_MIN);
   localparam logic                    RST_AT_MAX = (POS_ZERO >= POS_MAX);

   function automatic state_t decode(input logic [3:0] code);
      case (code)
         4'b0000: decode = S_IDLE;
         4'b1001: decode = S_PH1;
         4'b0101: decode = S_PH2;
         4'b0110: decode = S_PH3;
         4'b1010: decode = S_PH4;
         default: decode = S_BAD;
      endcase
   endfunction

   function automatic logic is_phase(input state_t s);
      is_phase = (s == S_PH1) || (s == S_PH2) || (s == S_PH3) || (s == S_PH4);
   endfunction

   function automatic logic [1:0] phase_idx(input state_t s);
      case (s)
         S_PH2:   phase_idx = 2'd1;
         S_PH3:   phase_idx = 2'd2;
         S_PH4:   phase_idx = 2'd3;
         default: phase_idx = 2'd0;
      endcase
   endfunction

   logic [3:0]              s1, s2, cand, acc_code, cnt;
   logic [3:0]              cand_next, cnt_next;
   logic                    load, accept;
   state_t                  state, state_next, new_state;
   logic [1:0]              diff;
   logic                    step_up, step_dn, fault_evt, energized;
   logic signed [POS_W-1:0] position, pos_next;
   logic                    step_pulse, step_dir, fault, at_min, at_max;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would let s2 see this cycle's s1.
   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         s1       <= 4'b0000;
         s2       <= 4'b0000;
         cand     <= 4'b0000;
         cnt      <= 4'd0;
         acc_code <= 4'b0000;
      end else begin
         s1   <= bus.coil;
         s2   <= s1;
         cand <= cand_next;
         cnt  <= cnt_next;
         if (accept) acc_code <= cand_next;
      end
   end

   // NOTE: every always_comb output gets a value on every path (defaults
   // first), otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      load      = (s2 != cand);
      cand_next = load ? s2 : cand;
      if (load)            cnt_next = 4'd1;
      else if (cnt == SC)  cnt_next = cnt;
      else                 cnt_next = cnt + 4'd1;
      // Accept only on the edge where the count first reaches the threshold.
      accept = (cnt_next == SC) && (load || (cnt != SC)) && (cand_next != acc_code);
   end

   assign new_state = decode(cand_next);

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) state <= S_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (accept) state_next = new_state;
   end

   always_comb begin
      step_up   = 1'b0;
      step_dn   = 1'b0;
      fault_evt = 1'b0;
      diff      = 2'd0;
      energized = is_phase(state);
      if (accept) begin
         if (new_state == S_BAD) begin
            fault_evt = 1'b1;
         end else if (is_phase(state) && is_phase(new_state)) begin
            diff = phase_idx(new_state) - phase_idx(state);
            case (diff)
               2'd1:    step_up   = 1'b1;
               2'd3:    step_dn   = 1'b1;
               2'd2:    fault_evt = 1'b1;
               default: ;
            endcase
         end
      end
   end

   // Zero overrides any step; steps hold at the numeric bounds instead of wrapping.
   always_comb begin
      pos_next = position;
      if (bus.zero)                         pos_next = POS_ZERO;
      else if (step_up && position != POS_TOP) pos_next = position + POS_ONE;
      else if (step_dn && position != POS_BOT) pos_next = position - POS_ONE;
   end

   always_ff @(posedge PCLK or negedge PRESERN) begin
      if (!PRESERN) begin
         position   <= POS_ZERO;
         step_pulse <= 1'b0;
         step_dir   <= 1'b0;
         fault      <= 1'b0;
         at_min     <= RST_AT_MIN;
         at_max     <= RST_AT_MAX;
      end else begin
         position   <= pos_next;
         step_pulse <= step_up | step_dn;
         if (step_up | step_dn) step_dir <= step_up;
         fault      <= fault_evt | (fault & ~bus.clr_fault);
         at_min     <= (pos_next <= POS_MIN);
         at_max     <= (pos_next >= POS_MAX);
      end
   end

   assign bus.position   = position;
   assign bus.step_pulse = step_pulse;
   assign bus.step_dir   = step_dir;
   assign bus.energized  = energized;
   assign bus.at_min     = at_min;
   assign bus.at_max     = at_max;
   assign bus.fault      = fault;

endmodule

// File: doc/coil_step_tracker.md
# coil_step_tracker

Per-axis position tracker that sits directly downstream of the stepper motor driver and consumes its 4-bit coil pattern. It synchronises and glitch-filters the pattern, decodes each phase transition into a signed step, and keeps an absolute step position. It also reports soft-limit flags, intended to feed the driver's table-edge inputs, and a sticky fault for illegal or skipped phases. One instance is used per axis (X, Y).

## Interface
- POS_W, 24: width of signed position counter
- STABLE_CYCLES, 4: consecutive identical synchronised samples required to accept a coil code (range 1–15)
- POS_MIN, -8000: soft lower limit (signed, POS_W bits)
- POS_MAX, 8000: soft upper limit (signed, POS_W bits)

- PCLK  in  1  system clock
- PRESERN  in  1  reset, asynchronous, active-low
- coil  in  4  coil pattern from driver (pulseX or pulseY), asynchronous to PCLK edges
- zero  in  1  synchronous request: position := 0
- clr_fault  in  1  synchronous request: clear fault
- position  out  POS_W  signed absolute step count
- step_pulse  out  1  one-cycle strobe per counted step
- step_dir  out  1  direction of last counted step: 1 = forward (+1), 0 = reverse
- energized  out  1  accepted code is a valid non-OFF phase
- at_min  out  1  position <= POS_MIN
- at_max  out  1  position >= POS_MAX
- fault  out  1  sticky: illegal code or skipped phase seen

## Operation
- Codes: OFF=0000; P1=1001, P2=0101, P3=0110, P4=1010. All 11 other codes are illegal.
- Input path: 2-flop synchroniser (s1, s2) on coil.
- Filter: a candidate register plus a stability counter.
  - When s2 differs from the candidate, load the candidate and set the counter to 1.
  - Otherwise, increment the counter, saturating at STABLE_CYCLES.
  - When the counter first reaches STABLE_CYCLES and the candidate differs from the accepted code, the candidate is accepted. That is one accept event.
- Decoder FSM states, per the accepted code: IDLE (OFF), PH1–PH4, BAD (illegal).
- On each accept event, the transition from the old accepted code to the new one determines the action:
  - PHn -> PH(n+1 mod 4): position +1, step_pulse, step_dir=1.
  - PHn -> PH(n-1 mod 4): position -1, step_pulse, step_dir=0.
  - PHn -> PH(n+2 mod 4): skipped phase. Set fault; no count; state moves to the new phase.
  - IDLE or BAD -> PHn: re-reference only. No count, no fault.
  - Any state -> IDLE: no count. This is a de-energize.
  - Any state -> illegal code: state becomes BAD, fault set, no count.
- Position arithmetic: signed POS_W bits, saturating at -2^(POS_W-1) and 2^(POS_W-1)-1. It never wraps. A step that would exceed the bound still pulses step_pulse but leaves position unchanged.
- zero: position := 0 on the next edge. If a step is accepted in the same cycle, zero wins for position, while step_pulse and step_dir still reflect the step.
- clr_fault: fault := 0 on the next edge. If a new fault event occurs in the same cycle, fault stays 1.
- at_min and at_max are registered comparisons of the updated position and are continuously valid. The soft limits do not block counting.
- energized = 1 in PH1–PH4, 0 in IDLE and BAD.

## Timing
- Reset (async assert, sync release internally not required):
  - s1, s2, candidate := 0000; counter := 0; state IDLE.
  - position := 0; step_pulse, step_dir, energized, fault := 0.
  - at_min := (0 <= POS_MIN); at_max := (0 >= POS_MAX). With defaults, both are 0.
- Latency: a coil change first sampled by s1 at edge k produces accept, step_pulse, position, step_dir, energized and fault at edge k+1+STABLE_CYCLES. at_min and at_max update at the same edge.
- Glitches: a code held for fewer than STABLE_CYCLES synchronised samples is never accepted and has no effect.
- step_pulse is high for exactly one cycle per accept event that counts.
- Minimum resolvable phase dwell is 2+STABLE_CYCLES PCLK cycles. Shorter dwells may be missed; a missed phase is then reported as a skip fault.
- Reset asserted mid-filter or mid-step discards all pending state immediately. After release, the first accepted phase is a re-reference and is not counted.

## Test plan
- Reset, then drive OFF -> 1001 -> 0101 -> 0110 -> 1010 -> 1001, each held 20 cycles. Required: 4 step_pulses, step_dir=1, position=4, energized=1, fault=0, and the first pulse 6 edges after the code change (STABLE_CYCLES=4).
- Continue from P1 with the reverse sequence 1010, 0110, 0101 -> position=1, step_dir=0, 3 pulses.
- Insert a 0101 glitch of 3 cycles inside a long 1001 hold -> no step_pulse, position unchanged. Then apply 1001 -> 0110 (skip) -> fault=1, position unchanged, energized=1. Then pulse clr_fault -> fault=0.
- Drive 0011 for 10 cycles -> fault=1, energized=0. Then 0101 -> no count, energized=1. Then 0110 -> position +1.
- Use POS_MIN=-3, POS_MAX=3 and 3 forward steps -> at_max=1 at position 3. A 4th step -> position 4, at_max=1. Assert zero in the same cycle as a step accept -> position=0, step_pulse=1, at_max=0.
- Use POS_W=4 and 9 forward steps -> position saturates at 7, with 9 step_pulses. Assert PRESERN low mid-hold -> all outputs at reset values immediately.
